// File: rtl/pipe_hazard_ctrl.sv
// Purpose : load-use / branch / memory-busy hazard controller for a 5-stage pipeline.
// Latency : all control outputs are combinational from inputs and the current FSM state.
// Backpr. : mem_busy freezes every pipeline register and holds the FSM and stall count.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   idex_memread/regwrite/rd        load in EX and its destination register
//   ifid_rs1/rs2, ifid_use_rs1/rs2  ID-stage source registers and whether each is read
//   ex_branch_taken                 redirect resolved in EX
//   mem_busy                        data memory not ready
//   pc_write/ifid_write/idex_write  register update enables
//   ctrl_bubble                     zero the ID/EX control fields (insert NOP)
//   ifid_flush/idex_flush           clear IF/ID and ID/EX
//   perf_stall_cycles/perf_flush_count  saturating counters, only with PIPE_HAZARD_PERF_CNT_EN
//
// Optional feature macro: PIPE_HAZARD_PERF_CNT_EN (adds the two performance counters).

module pipe_hazard_ctrl #(
  parameter int REG_AW          = 5,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              ctrl_bubble,
  output logic              ifid_flush,
  output logic              idex_flush
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cycles,
  output logic [CNT_W-1:0]  perf_flush_count
`endif
);

  // Counter sized for the largest legal stall length (4) plus one bit.
  localparam int CW = $clog2(4) + 1;

  if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 4) begin : g_bad_param
    $error("pipe_hazard_ctrl: LU_STALL_CYCLES must be in 1..4");
  end

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_hazard;

  // x0 is hard-wired zero, so a load targeting it can never create a dependency.
  // A match on both sources still yields a single hazard (one OR term).
  assign w_hazard = idex_memread & idex_regwrite & (idex_rd != '0) &
                    ((ifid_use_rs1 & (idex_rd == ifid_rs1)) |
                     (ifid_use_rs2 & (idex_rd == ifid_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ctrl_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    if (!rst_n) begin
      // Outputs are gated during reset so nothing updates while the core is held.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
    end else if (mem_busy) begin
      // Full freeze: state and count hold, so busy cycles extend a stall
      // without consuming any of it.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
    end else if (ex_branch_taken) begin
      // The redirect squashes the dependent instruction, so any stall in
      // progress is pointless and is abandoned.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == LU_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
      w_cnt_nxt   = r_cnt - CW'(1);
      if (r_cnt <= CW'(1)) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    end else if (w_hazard) begin
      // First stall cycle is taken here in RUN; LU_STALL covers the remainder.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        w_state_nxt = LU_STALL;
        w_cnt_nxt   = CW'(LU_STALL_CYCLES - 1);
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (ctrl_bubble && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + CNT_W'(1);
      if (ifid_flush  && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + CNT_W'(1);
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`else
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;

  // Output vector order: {pc_write, ifid_write, idex_write, ctrl_bubble, ifid_flush, idex_flush}
  localparam logic [5:0] NORM  = 6'b111000;
  localparam logic [5:0] STALL = 6'b001100;
  localparam logic [5:0] FRZ   = 6'b000000;
  localparam logic [5:0] FLSH  = 6'b111011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          idex_memread = 1'b0;
  logic          idex_regwrite = 1'b0;
  logic [AW-1:0] idex_rd = '0;
  logic [AW-1:0] ifid_rs1 = '0;
  logic [AW-1:0] ifid_rs2 = '0;
  logic          ifid_use_rs1 = 1'b0;
  logic          ifid_use_rs2 = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          mem_busy = 1'b0;

  logic pw1, fw1, ew1, cb1, ff1, xf1;
  logic pw3, fw3, ew3, cb3, ff3, xf3;
  logic [5:0] o1, o3;
  assign o1 = {pw1, fw1, ew1, cb1, ff1, xf1};
  assign o3 = {pw3, fw3, ew3, cb3, ff3, xf3};

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] ps1, pf1, ps3, pf3;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .LU_STALL_CYCLES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pw1), .ifid_write(fw1), .idex_write(ew1),
    .ctrl_bubble(cb1), .ifid_flush(ff1), .idex_flush(xf1)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(ps1), .perf_flush_count(pf1)
`endif
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .LU_STALL_CYCLES(3), .CNT_W(32)) u3 (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pw3), .ifid_write(fw3), .idex_write(ew3),
    .ctrl_bubble(cb3), .ifid_flush(ff3), .idex_flush(xf3)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(ps3), .perf_flush_count(pf3)
`endif
  );

  task automatic clr_in();
    idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = '0;
    ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_hz(input logic [AW-1:0] r);
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = r;
    ifid_rs1 = r; ifid_use_rs1 = 1'b1; ifid_rs2 = '0; ifid_use_rs2 = 1'b0;
  endtask

  task automatic test_reset();
    set_hz(5'd5);
    @(negedge clk); #1;
    total++; if (o1 !== FRZ) begin bad++; $display("FAIL reset_u1: got %b want %b", o1, FRZ); end
    total++; if (o3 !== FRZ) begin bad++; $display("FAIL reset_u3: got %b want %b", o3, FRZ); end
`ifdef PIPE_HAZARD_PERF_CNT_EN
    total++; if ({ps3, pf3} !== 64'd0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", ps3, pf3); end
`endif
    clr_in();
    rst_n = 1'b1; #1;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL release_u1: got %b want %b", o1, NORM); end
    total++; if (o3 !== NORM) begin bad++; $display("FAIL release_u3: got %b want %b", o3, NORM); end
    @(negedge clk);
  endtask

  task automatic test_stall_len();
    set_hz(5'd5); #1;
    total++; if (o1 !== STALL) begin bad++; $display("FAIL lu1_c1: got %b want %b", o1, STALL); end
    total++; if (o3 !== STALL) begin bad++; $display("FAIL lu3_c1: got %b want %b", o3, STALL); end
    @(negedge clk); clr_in(); #1;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL lu1_after: got %b want %b", o1, NORM); end
    total++; if (o3 !== STALL) begin bad++; $display("FAIL lu3_c2: got %b want %b", o3, STALL); end
    @(negedge clk); #1;
    total++; if (o3 !== STALL) begin bad++; $display("FAIL lu3_c3: got %b want %b", o3, STALL); end
    @(negedge clk); #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL lu3_after: got %b want %b", o3, NORM); end
    @(negedge clk);
  endtask

  task automatic test_busy();
    logic       hz_v   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       busy_v [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] exp_v  [6] = '{STALL, FRZ, FRZ, STALL, STALL, NORM};
    int n_bub = 0;
    for (int i = 0; i < 6; i++) begin
      clr_in();
      if (hz_v[i]) set_hz(5'd5);
      mem_busy = busy_v[i];
      #1;
      if (cb3) n_bub++;
      total++;
      if (o3 !== exp_v[i]) begin bad++; $display("FAIL busy_c%0d: got %b want %b", i, o3, exp_v[i]); end
      @(negedge clk);
    end
    total++; if (n_bub != 3) begin bad++; $display("FAIL busy_bubbles: got %0d want 3", n_bub); end
    clr_in();
  endtask

  task automatic test_no_stall();
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd0;
    ifid_rs1 = 5'd0; ifid_use_rs1 = 1; ifid_rs2 = 5'd0; ifid_use_rs2 = 1; #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL x0: got %b want %b", o3, NORM); end
    @(negedge clk); clr_in();
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd7;
    ifid_rs1 = 5'd3; ifid_use_rs1 = 1; ifid_rs2 = 5'd7; ifid_use_rs2 = 0; #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL rs2_unused: got %b want %b", o3, NORM); end
    @(negedge clk); clr_in();
    idex_memread = 0; idex_regwrite = 1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_use_rs1 = 1; #1;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL not_load: got %b want %b", o1, NORM); end
    @(negedge clk); clr_in();
    idex_memread = 1; idex_regwrite = 0; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_use_rs1 = 1; #1;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL no_regwrite: got %b want %b", o1, NORM); end
    @(negedge clk); clr_in();
    // Both sources match: still one load-use stall of the configured length.
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd9;
    ifid_rs1 = 5'd9; ifid_use_rs1 = 1; ifid_rs2 = 5'd9; ifid_use_rs2 = 1; #1;
    total++; if (o1 !== STALL) begin bad++; $display("FAIL dual_u1_c1: got %b want %b", o1, STALL); end
    @(negedge clk); clr_in(); #1;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL dual_u1_after: got %b want %b", o1, NORM); end
    total++; if (o3 !== STALL) begin bad++; $display("FAIL dual_u3_c2: got %b want %b", o3, STALL); end
    @(negedge clk); #1;
    total++; if (o3 !== STALL) begin bad++; $display("FAIL dual_u3_c3: got %b want %b", o3, STALL); end
    @(negedge clk); #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL dual_u3_after: got %b want %b", o3, NORM); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    set_hz(5'd5); #1;
    total++; if (o3 !== STALL) begin bad++; $display("FAIL br_c1: got %b want %b", o3, STALL); end
    @(negedge clk); clr_in(); ex_branch_taken = 1; #1;
    total++; if (o3 !== FLSH) begin bad++; $display("FAIL br_in_stall: got %b want %b", o3, FLSH); end
    total++; if (o1 !== FLSH) begin bad++; $display("FAIL br_run: got %b want %b", o1, FLSH); end
    @(negedge clk); clr_in(); #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL br_then_run: got %b want %b", o3, NORM); end
    @(negedge clk); set_hz(5'd5); ex_branch_taken = 1; #1;
    total++; if (o3 !== FLSH) begin bad++; $display("FAIL br_over_hz: got %b want %b", o3, FLSH); end
    @(negedge clk); clr_in(); #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL br_no_stall_entry: got %b want %b", o3, NORM); end
    @(negedge clk); mem_busy = 1; ex_branch_taken = 1; #1;
    total++; if (o1 !== FRZ) begin bad++; $display("FAIL busy_over_br: got %b want %b", o1, FRZ); end
    @(negedge clk); clr_in(); #1;
    total++; if (o1 !== NORM) begin bad++; $display("FAIL busy_br_after: got %b want %b", o1, NORM); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_hz(5'd5); #1;
    total++; if (o3 !== STALL) begin bad++; $display("FAIL rm_c1: got %b want %b", o3, STALL); end
    @(negedge clk); clr_in(); rst_n = 1'b0; #1;
    total++; if (o3 !== FRZ) begin bad++; $display("FAIL rm_in_reset: got %b want %b", o3, FRZ); end
    total++; if (o1 !== FRZ) begin bad++; $display("FAIL rm_in_reset_u1: got %b want %b", o1, FRZ); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL rm_release: got %b want %b", o3, NORM); end
    @(negedge clk); #1;
    total++; if (o3 !== NORM) begin bad++; $display("FAIL rm_no_bubble: got %b want %b", o3, NORM); end
`ifdef PIPE_HAZARD_PERF_CNT_EN
    total++; if ({ps3, pf3} !== 64'd0) begin bad++; $display("FAIL rm_perf_u3: got %0d/%0d want 0/0", ps3, pf3); end
    total++; if ({ps1, pf1} !== 64'd0) begin bad++; $display("FAIL rm_perf_u1: got %0d/%0d want 0/0", ps1, pf1); end
`endif
    @(negedge clk);
  endtask

`ifdef PIPE_HAZARD_PERF_CNT_EN
  task automatic test_perf();
    set_hz(5'd5); #1;
    @(negedge clk); clr_in(); ex_branch_taken = 1; #1;
    @(negedge clk); clr_in(); #1;
    total++; if (ps1 !== 32'd1 || pf1 !== 32'd1) begin bad++; $display("FAIL perf_u1: got %0d/%0d want 1/1", ps1, pf1); end
    total++; if (ps3 !== 32'd1 || pf3 !== 32'd1) begin bad++; $display("FAIL perf_u3: got %0d/%0d want 1/1", ps3, pf3); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_stall_len();
    test_busy();
    test_no_stall();
    test_branch();
    test_reset_mid();
`ifdef PIPE_HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
